gelato_warp_pc_stepper: RTL and testbench

// - Per-warp partner of the warp split table: consumes the selected entry (select_pc_if, slave side)
//   and returns the entry's next state (update_pc_if, master side).
// - Fetches the instruction at the selected PC from the I-cache, predecodes it for control flow,

---
 rtl/gelato_warp_pc_stepper_pkg.sv | 21 ++
 rtl/gelato_warp_pc_stepper_if.sv | 34 +++
 rtl/gelato_warp_pc_stepper_predecode.sv | 26 ++
 rtl/gelato_warp_pc_stepper.sv | 132 +++++++++++++
 tb/tb_gelato_warp_pc_stepper.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/gelato_warp_pc_stepper_pkg.sv
// Shared types for the warp PC stepper: FSM states, control-flow opcodes
// and the split table index width.
package gelato_warp_pc_stepper_pkg;

    localparam int SPLIT_TABLE_NUM_W = 4;

    typedef enum logic [2:0] {
        KICK,
        SEL,
        REQ,
        RSP,
        OUT,
        UPD
    } pc_stepper_state_t;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/gelato_warp_pc_stepper_if.sv
// Split table <-> PC stepper links: selected entry in, entry update out
// (update also carries the combinational thread mask lookup back).
interface gelato_select_pc_if #(
    parameter int ADDR_W   = 32,
    parameter int ST_NUM_W = 4
);
    logic                valid;
    logic [ADDR_W-1:0]   pc;
    logic [ST_NUM_W-1:0] split_table_num;

    modport master (output valid, pc, split_table_num);
    modport slave  (input  valid, pc, split_table_num);
endinterface

interface gelato_update_pc_if #(
    parameter int ADDR_W     = 32,
    parameter int ST_NUM_W   = 4,
    parameter int THREAD_NUM = 32
);
    logic                  valid;
    logic [ST_NUM_W-1:0]   split_table_num;
    logic [ADDR_W-1:0]     pc;
    logic                  stall;
    logic [THREAD_NUM-1:0] thread_mask;

    modport master (
        output valid, split_table_num, pc, stall,
        input  thread_mask
    );
    modport slave (
        input  valid, split_table_num, pc, stall,
        output thread_mask
    );
endinterface

// File: rtl/gelato_warp_pc_stepper_predecode.sv
// Control-flow predecode: control transfers park the entry at its own PC,
// everything else falls through to pc+4.
module gelato_inst_predecode
    import gelato_warp_pc_stepper_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [6:0]        opcode,
    input  logic [ADDR_W-1:0] pc,
    output logic              stall,
    output logic [ADDR_W-1:0] next_pc
);

    always_comb begin
        stall   = 1'b0;
        next_pc = pc + ADDR_W'(4);
        case (opcode)
            OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_SYSTEM: begin
                stall   = 1'b1;
                next_pc = pc;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/gelato_warp_pc_stepper.sv
// Per-warp PC stepper: fetches the selected split table entry's instruction,
// hands it to decode, then writes the entry's next PC / stall back.
module gelato_warp_pc_stepper
    import gelato_warp_pc_stepper_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int INST_W     = 32,
    parameter int THREAD_NUM = 32,
    parameter int ST_NUM_W   = SPLIT_TABLE_NUM_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rdy,
    gelato_select_pc_if.slave     select,
    gelato_update_pc_if.master    update,
    output logic                  ic_req_valid,
    input  logic                  ic_req_ready,
    output logic [ADDR_W-1:0]     ic_req_addr,
    input  logic                  ic_rsp_valid,
    input  logic [INST_W-1:0]     ic_rsp_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_W-1:0]     inst_data,
    output logic [ADDR_W-1:0]     inst_pc,
    output logic [THREAD_NUM-1:0] inst_thread_mask,
    output logic [ST_NUM_W-1:0]   inst_split_table_num
);

    pc_stepper_state_t state, state_nx;

    logic [ADDR_W-1:0]     pc_q;
    logic [ST_NUM_W-1:0]   num_q;
    logic [INST_W-1:0]     inst_q;
    logic [THREAD_NUM-1:0] mask_q;
    logic                  pass_q;
    logic                  got_q;
    logic                  rsp_hit;
    logic                  pd_stall;
    logic [ADDR_W-1:0]     pd_next_pc;

    gelato_inst_predecode #(
        .ADDR_W (ADDR_W)
    ) u_predecode (
        .opcode  (inst_q[6:0]),
        .pc      (pc_q),
        .stall   (pd_stall),
        .next_pc (pd_next_pc)
    );

    // A response that arrived while frozen still counts once rdy returns.
    assign rsp_hit = ic_rsp_valid || got_q;

    always_comb begin
        state_nx = state;
        if (rdy) begin
            unique case (state)
                KICK: state_nx = SEL;
                SEL:  state_nx = select.valid ? REQ : UPD;
                REQ:  if (ic_req_ready) state_nx = RSP;
                RSP:  if (rsp_hit) state_nx = OUT;
                OUT:  if (inst_ready) state_nx = UPD;
                UPD:  state_nx = SEL;
                default: state_nx = KICK;
            endcase
        end
    end

    always_comb begin
        update.valid = rst_n && rdy && (state == KICK || state == UPD);
        update.split_table_num = num_q;
        update.pc    = pc_q;
        update.stall = 1'b1;
        unique case (state)
            KICK: begin
                update.split_table_num = '0;
                update.pc    = '0;
                update.stall = 1'b0;
            end
            SEL: begin
                update.split_table_num = select.split_table_num;
                update.pc    = select.pc;
            end
            UPD: begin
                if (!pass_q) begin
                    update.pc    = pd_next_pc;
                    update.stall = pd_stall;
                end
            end
            default: ;
        endcase
    end

    assign ic_req_valid = rst_n && (state == REQ);
    assign ic_req_addr  = pc_q;

    assign inst_valid           = rst_n && (state == OUT);
    assign inst_data            = inst_q;
    assign inst_pc              = pc_q;
    assign inst_thread_mask     = mask_q;
    assign inst_split_table_num = num_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= KICK;
            pc_q   <= '0;
            num_q  <= '0;
            inst_q <= '0;
            mask_q <= '0;
            pass_q <= 1'b0;
            got_q  <= 1'b0;
        end else begin
            if (rdy) begin
                state <= state_nx;
            end
            if (rdy && state == SEL) begin
                pc_q   <= select.pc;
                num_q  <= select.split_table_num;
                pass_q <= !select.valid;
            end
            if (state == RSP && ic_rsp_valid && !got_q) begin
                inst_q <= ic_rsp_data;
                got_q  <= 1'b1;
            end
            // update.split_table_num already shows num_q here.
            if (rdy && state == RSP && rsp_hit) begin
                got_q  <= 1'b0;
                mask_q <= update.thread_mask;
            end
        end
    end

endmodule

// File: tb/tb_gelato_warp_pc_stepper.sv
// Directed bench for the warp PC stepper with a split table mask stub.
module tb_gelato_warp_pc_stepper;

    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic        ic_req_valid;
    logic        ic_req_ready;
    logic [31:0] ic_req_addr;
    logic        ic_rsp_valid;
    logic [31:0] ic_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] inst_thread_mask;
    logic [3:0]  inst_split_table_num;

    int checks = 0;
    int errors = 0;

    gelato_select_pc_if #(.ADDR_W(32), .ST_NUM_W(4)) sel ();
    gelato_update_pc_if #(.ADDR_W(32), .ST_NUM_W(4), .THREAD_NUM(32)) upd ();

    assign upd.thread_mask = {28'hA5A5000, upd.split_table_num};

    gelato_warp_pc_stepper dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .rdy                  (rdy),
        .select               (sel),
        .update               (upd),
        .ic_req_valid         (ic_req_valid),
        .ic_req_ready         (ic_req_ready),
        .ic_req_addr          (ic_req_addr),
        .ic_rsp_valid         (ic_rsp_valid),
        .ic_rsp_data          (ic_rsp_data),
        .inst_valid           (inst_valid),
        .inst_ready           (inst_ready),
        .inst_data            (inst_data),
        .inst_pc              (inst_pc),
        .inst_thread_mask     (inst_thread_mask),
        .inst_split_table_num (inst_split_table_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts at an update strobe; ends at the next strobe.
    task automatic fetch(input logic [31:0] pc, input logic [3:0] num,
                         input logic [31:0] inst, input logic [31:0] exp_pc,
                         input logic exp_stall);
        sel.valid = 1'b1;
        sel.pc = pc;
        sel.split_table_num = num;
        tick();
        chk("sel_upd_valid", upd.valid, 0);
        chk("sel_req_valid", ic_req_valid, 0);
        tick();
        chk("req_valid", ic_req_valid, 1);
        chk("req_addr", ic_req_addr, pc);
        chk("req_num", upd.split_table_num, num);
        tick();
        chk("rsp_req_valid", ic_req_valid, 0);
        ic_rsp_valid = 1'b1;
        ic_rsp_data = inst;
        tick();
        ic_rsp_valid = 1'b0;
        chk("out_valid", inst_valid, 1);
        chk("out_pc", inst_pc, pc);
        chk("out_data", inst_data, inst);
        chk("out_mask", inst_thread_mask, {28'hA5A5000, num});
        chk("out_num", inst_split_table_num, num);
        tick();
        chk("upd_valid", upd.valid, 1);
        chk("upd_num", upd.split_table_num, num);
        chk("upd_pc", upd.pc, exp_pc);
        chk("upd_stall", upd.stall, exp_stall);
        chk("upd_inst_valid", inst_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        rdy = 1'b1;
        sel.valid = 1'b0;
        sel.pc = '0;
        sel.split_table_num = '0;
        ic_req_ready = 1'b1;
        ic_rsp_valid = 1'b0;
        ic_rsp_data = '0;
        inst_ready = 1'b1;
        tick();
        tick();
        chk("rst_upd_valid", upd.valid, 0);
        chk("rst_req_valid", ic_req_valid, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_inst_data", inst_data, 0);

        rst_n = 1'b1;
        #1;
        chk("kick_valid", upd.valid, 1);
        chk("kick_num", upd.split_table_num, 0);
        chk("kick_pc", upd.pc, 0);
        chk("kick_stall", upd.stall, 0);

        fetch(32'h100, 4'd2, 32'h0000_0013, 32'h104, 1'b0);
        fetch(32'h200, 4'd3, 32'hFE00_0EE3, 32'h200, 1'b1);

        sel.valid = 1'b0;
        sel.pc = 32'h40;
        sel.split_table_num = 4'd1;
        tick();
        chk("br_single_strobe", upd.valid, 0);
        chk("pass_no_req", ic_req_valid, 0);
        tick();
        chk("pass_no_req2", ic_req_valid, 0);
        chk("pass_valid", upd.valid, 1);
        chk("pass_pc", upd.pc, 32'h40);
        chk("pass_num", upd.split_table_num, 1);
        chk("pass_stall", upd.stall, 1);

        inst_ready = 1'b0;
        sel.valid = 1'b1;
        sel.pc = 32'h300;
        sel.split_table_num = 4'd4;
        tick();
        tick();
        tick();
        ic_rsp_valid = 1'b1;
        ic_rsp_data = 32'h0010_0093;
        tick();
        ic_rsp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("bp_inst_valid", inst_valid, 1);
            chk("bp_inst_pc", inst_pc, 32'h300);
            chk("bp_inst_data", inst_data, 32'h0010_0093);
            chk("bp_inst_mask", inst_thread_mask, 32'hA5A5_0004);
            chk("bp_upd_valid", upd.valid, 0);
            tick();
        end
        inst_ready = 1'b1;
        tick();
        rdy = 1'b0;
        #1;
        chk("frz_upd_valid", upd.valid, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_upd_valid", upd.valid, 0);
            chk("frz_inst_valid", inst_valid, 0);
        end
        rdy = 1'b1;
        #1;
        chk("frz_release_valid", upd.valid, 1);
        chk("frz_release_pc", upd.pc, 32'h304);
        chk("frz_release_stall", upd.stall, 0);
        chk("frz_release_num", upd.split_table_num, 4);

        fetch(32'hFFFF_FFFC, 4'd7, 32'h0000_0013, 32'h0, 1'b0);

        sel.valid = 1'b1;
        sel.pc = 32'h500;
        sel.split_table_num = 4'd5;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_upd_valid", upd.valid, 0);
        chk("mid_rst_req_valid", ic_req_valid, 0);
        chk("mid_rst_inst_valid", inst_valid, 0);
        chk("mid_rst_inst_pc", inst_pc, 0);
        chk("mid_rst_num", upd.split_table_num, 0);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_kick_valid", upd.valid, 1);
        chk("mid_rst_kick_pc", upd.pc, 0);
        chk("mid_rst_kick_stall", upd.stall, 0);

        sel.valid = 1'b1;
        sel.pc = 32'h600;
        sel.split_table_num = 4'd6;
        ic_rsp_valid = 1'b1;
        ic_rsp_data = 32'hDEAD_BEEF;
        tick();
        tick();
        ic_rsp_valid = 1'b0;
        chk("stray_req_valid", ic_req_valid, 1);
        tick();
        rdy = 1'b0;
        ic_rsp_valid = 1'b1;
        ic_rsp_data = 32'h0000_006F;
        tick();
        ic_rsp_valid = 1'b0;
        tick();
        chk("cap_hold_inst_valid", inst_valid, 0);
        rdy = 1'b1;
        tick();
        chk("cap_inst_valid", inst_valid, 1);
        chk("cap_inst_data", inst_data, 32'h0000_006F);
        chk("cap_inst_pc", inst_pc, 32'h600);
        chk("cap_inst_mask", inst_thread_mask, 32'hA5A5_0006);
        tick();
        chk("jal_upd_valid", upd.valid, 1);
        chk("jal_upd_pc", upd.pc, 32'h600);
        chk("jal_upd_stall", upd.stall, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
